// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage access controller: width codes,
// FSM encoding, default wait limit and the alignment rule.
package mem_ctrl_pkg;

  localparam logic [2:0] BOP_WORD = 3'b001;
  localparam logic [2:0] BOP_BYTE = 3'b010;
  localparam logic [2:0] BOP_HALF = 3'b011;

  localparam int WAIT_MAX_DEF = 15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  // Fields held for the lifetime of one memory access.
  typedef struct packed {
    logic       we;
    logic [2:0] byteop;
    logic       uns;
    logic [1:0] lo;
  } req_t;

  // Unknown width codes are treated as misaligned so they never reach memory.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lo);
    case (op)
      BOP_BYTE: is_misaligned = 1'b0;
      BOP_HALF: is_misaligned = lo[0];
      BOP_WORD: is_misaligned = (lo != 2'b00);
      default:  is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering: store byte enables and lane replication, load lane
// extraction with sign/zero extension, and the misalignment flag.
module lane_align
  import mem_ctrl_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  byteop,
  input  logic        uns,
  input  logic [1:0]  lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        misaligned,
  output logic [3:0]  byteen,
  output logic [31:0] wlane,
  output logic [31:0] rext
);

  logic [7:0]  rb;
  logic [15:0] rh;

  // Lane decode; loads never drive byte enables or write data.
  always_comb begin
    byteen     = 4'b0000;
    wlane      = 32'h0;
    rext       = 32'h0;
    misaligned = is_misaligned(byteop, lo);
    case (lo)
      2'd0:    rb = rdata[7:0];
      2'd1:    rb = rdata[15:8];
      2'd2:    rb = rdata[23:16];
      default: rb = rdata[31:24];
    endcase
    rh = lo[1] ? rdata[31:16] : rdata[15:0];
    case (byteop)
      BOP_BYTE: begin
        byteen = 4'b0001 << lo;
        wlane  = {4{wdata[7:0]}};
        rext   = uns ? {24'h0, rb} : {{24{rb[7]}}, rb};
      end
      BOP_HALF: begin
        byteen = lo[1] ? 4'b1100 : 4'b0011;
        wlane  = {2{wdata[15:0]}};
        rext   = uns ? {16'h0, rh} : {{16{rh[15]}}, rh};
      end
      BOP_WORD: begin
        byteen = 4'b1111;
        wlane  = wdata;
        rext   = rdata;
      end
      default: ;
    endcase
    if (!we) begin
      byteen = 4'b0000;
      wlane  = 32'h0;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage access controller: accepts one load/store at a time, issues it
// to memory with registered bus outputs, and returns a one-cycle response.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  ByteOp,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byteen,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        exc_bus
);

  state_t      state, nstate;
  req_t        rq;
  logic [3:0]  wait_cnt;
  logic [3:0]  byteen_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        adel_q, ades_q, bus_q;
  logic        timeout;

  logic        la_we, la_uns, la_mis;
  logic [2:0]  la_op;
  logic [1:0]  la_lo;
  logic [3:0]  la_byteen;
  logic [31:0] la_wlane, la_rext;

  // In IDLE the aligner looks at the incoming request; afterwards at the
  // latched one so load data is extracted with the original lane info.
  assign la_we  = (state == S_IDLE) ? req_we          : rq.we;
  assign la_op  = (state == S_IDLE) ? ByteOp          : rq.byteop;
  assign la_uns = (state == S_IDLE) ? req_unsigned    : rq.uns;
  assign la_lo  = (state == S_IDLE) ? req_addr[1:0]   : rq.lo;

  lane_align u_align (
    .we         (la_we),
    .byteop     (la_op),
    .uns        (la_uns),
    .lo         (la_lo),
    .wdata      (req_wdata),
    .rdata      (mem_rdata),
    .misaligned (la_mis),
    .byteen     (la_byteen),
    .wlane      (la_wlane),
    .rext       (la_rext)
  );

  assign timeout = (state == S_ISSUE) && !mem_ready && (wait_cnt == 4'(WAIT_MAX - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nstate;
  end

  // Next-state decode.
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE:  if (req_valid) nstate = la_mis ? S_RESP : S_ISSUE;
      S_ISSUE: if (mem_ready || timeout) nstate = S_RESP;
      S_RESP:  nstate = S_IDLE;
      default: nstate = S_IDLE;
    endcase
  end

  // Request latch, wait counter and response/exception registers. Response
  // registers are loaded on entry to RESP and cleared on leaving it, so they
  // read as zero whenever resp_valid is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rq       <= '0;
      wait_cnt <= 4'h0;
      byteen_q <= 4'h0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
      adel_q   <= 1'b0;
      ades_q   <= 1'b0;
      bus_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          if (la_mis) begin
            adel_q  <= !req_we;
            ades_q  <= req_we;
            rdata_q <= 32'h0;
          end else begin
            rq       <= '{we: req_we, byteop: ByteOp, uns: req_unsigned, lo: req_addr[1:0]};
            addr_q   <= {req_addr[31:2], 2'b00};
            byteen_q <= la_byteen;
            wdata_q  <= la_wlane;
            wait_cnt <= 4'h0;
          end
        end
        S_ISSUE: begin
          if (mem_ready) begin
            rdata_q <= rq.we ? 32'h0 : la_rext;
          end else if (timeout) begin
            bus_q   <= 1'b1;
            rdata_q <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 4'h1;
          end
        end
        S_RESP: begin
          adel_q  <= 1'b0;
          ades_q  <= 1'b0;
          bus_q   <= 1'b0;
          rdata_q <= 32'h0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == S_IDLE);
  assign mem_req    = (state == S_ISSUE);
  assign mem_we     = (state == S_ISSUE) && rq.we;
  assign mem_addr   = addr_q;
  assign mem_byteen = byteen_q;
  assign mem_wdata  = wdata_q;
  assign resp_valid = (state == S_RESP);
  assign resp_rdata = rdata_q;
  assign exc_adel   = adel_q;
  assign exc_ades   = ades_q;
  assign exc_bus    = bus_q;

endmodule
